// File: rtl/lzss_feed_ctrl.sv
// Host-to-LZSS-core feeder: serializes 32-bit host words MSB-byte-first, triggers flush, counts codewords.
// Optional flush watchdog enabled by defining LZSS_FEED_TIMEOUT_EN.
module lzss_feed_ctrl #(
    parameter int CNT_W  = 12,
    parameter int WCNT_W = 11,
    parameter int TO_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       data,
    input  logic              data_valid,
    input  logic              drop_done,
    output logic              busy,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              flush,
    input  logic              flush_done,
    input  logic              cw_valid,
    output logic [CNT_W-1:0]  enc_num,
    output logic [WCNT_W-1:0] word_cnt,
    output logic              finish,
    output logic              timeout
);

    // state   | meaning
    // S_IDLE  | ready for a host word, or start flush once drop is latched
    // S_SEND  | presenting bytes of the latched word to the core
    // S_FLUSH | one-cycle flush request to the core
    // S_WAIT  | waiting for the core to finish flushing
    // S_DONE  | stream complete, held until reset
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_FLUSH, S_WAIT, S_DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        drop_q;
    logic        accept, xfer, last_xfer, to_hit;
    logic        busy_nx, byte_valid_nx, flush_nx, finish_nx;

    assign accept    = (state == S_IDLE) && data_valid;
    assign xfer      = (state == S_SEND) && byte_ready;
    assign last_xfer = xfer && (idx_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            byte_valid <= 1'b0;
            flush      <= 1'b0;
            finish     <= 1'b0;
        end else begin
            state      <= state_nx;
            busy       <= busy_nx;
            byte_valid <= byte_valid_nx;
            flush      <= flush_nx;
            finish     <= finish_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (data_valid)  state_nx = S_SEND;
                else if (drop_q) state_nx = S_FLUSH;
            end
            S_SEND: begin
                if (last_xfer) state_nx = drop_q ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: state_nx = S_WAIT;
            S_WAIT: begin
                if (flush_done || to_hit) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_nx       = (state_nx != S_IDLE);
        byte_valid_nx = (state_nx == S_SEND);
        flush_nx      = (state_nx == S_FLUSH);
        finish_nx     = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q   <= '0;
            idx_q    <= '0;
            byte_out <= '0;
            drop_q   <= 1'b0;
            word_cnt <= '0;
            enc_num  <= '0;
        end else begin
            if (drop_done) drop_q <= 1'b1;
            if (accept) begin
                word_q   <= data;
                idx_q    <= 2'd0;
                byte_out <= data[31:24];
                if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            end else if (xfer) begin
                idx_q <= idx_q + 2'd1;
                case (idx_q)
                    2'd0:    byte_out <= word_q[23:16];
                    2'd1:    byte_out <= word_q[15:8];
                    2'd2:    byte_out <= word_q[7:0];
                    default: byte_out <= 8'h00;
                endcase
            end
            if (cw_valid && (enc_num != '1)) enc_num <= enc_num + 1'b1;
        end
    end

`ifdef LZSS_FEED_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // Loaded while in FLUSH so WAIT lasts at most TO_CYC cycles.
    assign to_hit = (state == S_WAIT) && (to_cnt == '0) && !flush_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == S_FLUSH)
                to_cnt <= TO_W'(TO_CYC - 1);
            else if ((state == S_WAIT) && (to_cnt != '0))
                to_cnt <= to_cnt - 1'b1;
            if (to_hit) timeout <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lzss_feed_ctrl.sv
// Scoreboard bench for lzss_feed_ctrl: expected bytes queued on word drive, popped on each byte transfer.
module tb_lzss_feed_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic        data_valid = 1'b0;
    logic        drop_done = 1'b0;
    logic        busy;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        flush;
    logic        flush_done = 1'b0;
    logic        cw_valid = 1'b0;
    logic [11:0] enc_num;
    logic [10:0] word_cnt;
    logic        finish;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int xfers  = 0;
    int flushes = 0;
    logic [7:0] exp_q[$];

    lzss_feed_ctrl #(.CNT_W(12), .WCNT_W(11), .TO_CYC(16)) dut (
        .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
        .drop_done(drop_done), .busy(busy), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .flush(flush),
        .flush_done(flush_done), .cw_valid(cw_valid), .enc_num(enc_num),
        .word_cnt(word_cnt), .finish(finish), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Byte monitor: sampled on the falling edge, between driven input changes and the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid && byte_ready) begin
                xfers++;
                if (exp_q.size() == 0) chk("byte_unexpected", {24'h0, byte_out}, 32'hffff_ffff);
                else chk("byte", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
            end
            if (flush) flushes++;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; data_valid = 1'b0; drop_done = 1'b0;
        flush_done = 1'b0; cw_valid = 1'b0; byte_ready = 1'b1;
        #1;
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_bvalid"},   byte_valid, 0);
        chk({tag, "_byte"},     byte_out, 0);
        chk({tag, "_flush"},    flush, 0);
        chk({tag, "_enc"},      enc_num, 0);
        chk({tag, "_wcnt"},     word_cnt, 0);
        chk({tag, "_finish"},   finish, 0);
        chk({tag, "_timeout"},  timeout, 0);
        exp_q.delete();
        @(negedge clk); reset = 1'b0;
        cyc();
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 60) begin cyc(); c++; end
        if (busy) chk({tag, "_idle_bound"}, busy, 0);
    endtask

    task automatic wait_flush(input string tag);
        int c = 0;
        while (!flush && c < 60) begin cyc(); c++; end
        chk({tag, "_flush_seen"}, flush, 1);
    endtask

    // Presents one word in an IDLE cycle; returns in the cycle after acceptance.
    task automatic send_word(input logic [31:0] w, input logic drop, input string tag);
        wait_idle(tag);
        data = w; data_valid = 1'b1; drop_done = drop;
        exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
        cyc();
        data_valid = 1'b0; drop_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int x0, f0, c;
        logic [7:0] held;

        // Single word with drop in the same cycle, then flush handshake.
        do_reset("rst0");
        x0 = xfers; f0 = flushes;
        send_word(32'h4142_4344, 1'b1, "t1");
        chk("t1_busy_first", busy, 1);
        chk("t1_bvalid_first", byte_valid, 1);
        repeat (4) cyc();
        chk("t1_xfers", xfers - x0, 4);
        chk("t1_flush", flush, 1);
        cyc();
        chk("t1_flush_one_cycle", flush, 0);
        chk("t1_finish_early", finish, 0);
        flush_done = 1'b1; cyc(); flush_done = 1'b0;
        chk("t1_finish", finish, 1);
        chk("t1_busy_done", busy, 1);
        chk("t1_wcnt", word_cnt, 1);
        chk("t1_flush_pulses", flushes - f0, 1);

        // 170 words back-to-back with 318 codeword pulses in parallel.
        do_reset("rst1");
        fork
            begin
                for (int i = 0; i < 170; i++)
                    send_word(32'h1000_0000 + i * 32'h0103_0507, i == 169, "t2");
            end
            begin
                for (int k = 0; k < 318; k++) begin
                    cw_valid = 1'b1; cyc(); cw_valid = 1'b0; cyc();
                end
            end
        join
        wait_flush("t2");
        cyc();
        flush_done = 1'b1; cyc(); flush_done = 1'b0;
        chk("t2_finish", finish, 1);
        chk("t2_enc", enc_num, 318);
        chk("t2_wcnt", word_cnt, 170);
        chk("t2_q_empty", exp_q.size(), 0);
        // Codewords still count in DONE, and the counter saturates.
        cw_valid = 1'b1; repeat (4100) cyc(); cw_valid = 1'b0;
        chk("t2_enc_sat", enc_num, 12'hfff);

        // Stall mid-word and a host word presented while busy.
        do_reset("rst2");
        send_word(32'hA1B2_C3D4, 1'b0, "t3");
        cyc();
        byte_ready = 1'b0;
        held = byte_out;
        chk("t3_held_byte", held, 8'hB2);
        for (int s = 0; s < 3; s++) begin
            if (s == 0) begin data = 32'hDEAD_BEEF; data_valid = 1'b1; end
            cyc();
            data_valid = 1'b0;
            chk("t3_stall_byte", byte_out, 8'hB2);
            chk("t3_stall_busy", busy, 1);
            chk("t3_stall_bvalid", byte_valid, 1);
        end
        byte_ready = 1'b1;
        wait_idle("t3");
        chk("t3_wcnt", word_cnt, 1);
        chk("t3_q_empty", exp_q.size(), 0);
        chk("t3_no_flush", flush, 0);

        // Reset while waiting for flush_done, then normal operation.
        do_reset("rst3");
        cw_valid = 1'b1; cyc(); cyc(); cw_valid = 1'b0;
        chk("t4_enc_pre", enc_num, 2);
        send_word(32'h5566_7788, 1'b1, "t4");
        wait_flush("t4");
        cyc();
        chk("t4_in_wait_busy", busy, 1);
        #2;
        do_reset("t4_midwait");
        send_word(32'h0102_0304, 1'b0, "t4b");
        wait_idle("t4b");
        chk("t4_wcnt", word_cnt, 1);
        chk("t4_q_empty", exp_q.size(), 0);
        chk("t4_finish", finish, 0);

        // Flush watchdog: flush_done never arrives.
        do_reset("rst4");
        send_word(32'hCAFE_F00D, 1'b1, "t5");
        wait_flush("t5");
        c = 0;
        while (!finish && c < 40) begin cyc(); c++; end
`ifdef LZSS_FEED_TIMEOUT_EN
        chk("t5_finish", finish, 1);
        chk("t5_timeout", timeout, 1);
        chk("t5_latency", c, 17);
`else
        chk("t5_no_finish", finish, 0);
        chk("t5_no_timeout", timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
